psum_window_acc: RTL and testbench

Parametrised, multi-lane partial-sum window accumulator. Each lane sums the last WIN accepted partial sums, either as a sliding window or as non-overlapping (tumbling) blocks. Results use an exact-width running sum and a selectable saturate/wrap output conversion. The block sits between the PE array partial-sum outputs and the output buffer, with valid/ready handshakes on both sides.

---
 rtl/psum_window_acc_if.sv | 26 ++
 rtl/psum_window_acc.sv | 139 +++++++++++++
 tb/tb_psum_window_acc.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/psum_window_acc_if.sv
// Handshake bundle for the partial-sum window accumulator: the input
// stream from the PE array and the output stream toward the output buffer.
interface psum_window_acc_if #(
  parameter int LANES  = 1,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) ();
  logic [LANES*DATA_W-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*ACC_W-1:0]  out_data;
  logic                    out_valid;
  logic                    out_ready;

  // Producer/consumer side (drives samples in, consumes results)
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Accumulator side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/psum_window_acc.sv
// Multi-lane partial-sum window accumulator. Each lane keeps a ring buffer
// and an exact-width running sum; the window is either sliding or tumbling.
// All lanes share one input/output handshake and one fill/pointer state.
module psum_window_acc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int WIN    = 3,
  parameter int LANES  = 1,
  parameter bit SAT    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       mode,
  psum_window_acc_if.slave           bus,
  output logic [$clog2(WIN+1)-1:0]   fill,
  output logic [LANES-1:0]           ovf
);

  localparam int CNT_W = $clog2(WIN + 1);
  localparam int PTR_W = $clog2(WIN);
  localparam int SUM_W = DATA_W + $clog2(WIN);

  logic             flush;
  logic             accept;
  logic             eff_mode;
  logic             produce;
  logic             tumble_done;
  logic [CNT_W-1:0] fill_reg;
  logic [CNT_W-1:0] fill_next;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic             mode_reg;
  logic             out_valid_reg;

  assign flush        = rst || clr;
  // Ready never looks at in_valid, so there is no valid->ready loop upstream.
  assign bus.in_ready = en && !rst && !clr && (!out_valid_reg || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_reg;
  assign fill          = fill_reg;

  // Mode in force for this accept, post-accept fill and output decision
  always_comb begin
    eff_mode  = (fill_reg == '0) ? mode : mode_reg;
    fill_next = fill_reg + 1'b1;
    if (!eff_mode && (fill_reg == CNT_W'(WIN)))
      fill_next = fill_reg;
    produce     = accept && (fill_next == CNT_W'(WIN));
    tumble_done = produce && eff_mode;
  end

  // Shared window bookkeeping and output-valid register
  always_ff @(posedge clk) begin
    if (flush) begin
      fill_reg      <= '0;
      wr_ptr_reg    <= '0;
      mode_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        if (fill_reg == '0)
          mode_reg <= mode;
        fill_reg <= tumble_done ? '0 : fill_next;
        // Tumbling never touches the ring, so the pointer stays at 0 there.
        if (!eff_mode)
          wr_ptr_reg <= (wr_ptr_reg == PTR_W'(WIN - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (produce)
        out_valid_reg <= 1'b1;
      else if (en && bus.out_ready)
        out_valid_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [DATA_W-1:0] buf_mem [WIN];
    logic signed [SUM_W-1:0]  sum_reg;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [DATA_W-1:0] in_s;
    logic signed [DATA_W-1:0] old_s;
    logic signed [ACC_W-1:0]  conv;
    logic                     conv_ovf;
    logic signed [ACC_W-1:0]  out_lane_reg;
    logic                     ovf_lane_reg;

    assign in_s  = bus.in_data[gi*DATA_W +: DATA_W];
    // Ring entries are zero while filling, so this is 0 until the window is full.
    assign old_s = eff_mode ? '0 : buf_mem[wr_ptr_reg];
    assign sum_next = sum_reg + SUM_W'(in_s) - SUM_W'(old_s);

    if (ACC_W >= SUM_W) begin : g_ext
      assign conv     = ACC_W'(sum_next);
      assign conv_ovf = 1'b0;
    end else if (SAT) begin : g_sat
      localparam logic signed [SUM_W-1:0] MAX_S = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
      localparam logic signed [SUM_W-1:0] MIN_S = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
      // Clamp to the signed output range, flagging any clamp
      always_comb begin
        conv     = sum_next[ACC_W-1:0];
        conv_ovf = 1'b0;
        if (sum_next > MAX_S) begin
          conv     = {1'b0, {(ACC_W-1){1'b1}}};
          conv_ovf = 1'b1;
        end else if (sum_next < MIN_S) begin
          conv     = {1'b1, {(ACC_W-1){1'b0}}};
          conv_ovf = 1'b1;
        end
      end
    end else begin : g_wrap
      assign conv     = sum_next[ACC_W-1:0];
      assign conv_ovf = (SUM_W'(conv) != sum_next);
    end

    // Per-lane ring, running sum, output data and sticky overflow
    always_ff @(posedge clk) begin
      if (flush) begin
        sum_reg <= '0;
        for (int i = 0; i < WIN; i++)
          buf_mem[i] <= '0;
        out_lane_reg <= '0;
        ovf_lane_reg <= 1'b0;
      end else if (accept) begin
        sum_reg <= tumble_done ? '0 : sum_next;
        if (!eff_mode)
          buf_mem[wr_ptr_reg] <= in_s;
        if (produce) begin
          out_lane_reg <= conv;
          if (conv_ovf)
            ovf_lane_reg <= 1'b1;
        end
      end
    end

    assign bus.out_data[gi*ACC_W +: ACC_W] = out_lane_reg;
    assign ovf[gi] = ovf_lane_reg;
  end

endmodule

// File: tb/tb_psum_window_acc.sv
// Directed bench for psum_window_acc: sliding, tumbling, backpressure/en,
// clr behaviour, and saturate/wrap conversion on narrow outputs.
module tb_psum_window_acc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // DUT A: WIN=3, LANES=1, ACC_W=16, saturating
  psum_window_acc_if #(.LANES(1), .DATA_W(8), .ACC_W(16)) if_a ();
  logic       en_a, clr_a, mode_a;
  logic [1:0] fill_a;
  logic [0:0] ovf_a;
  psum_window_acc #(.DATA_W(8), .ACC_W(16), .WIN(3), .LANES(1), .SAT(1'b1)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .clr(clr_a), .mode(mode_a),
    .bus(if_a.slave), .fill(fill_a), .ovf(ovf_a));

  // DUT B / C: ACC_W=8, saturate vs wrap, driven with identical stimulus
  psum_window_acc_if #(.LANES(1), .DATA_W(8), .ACC_W(8)) if_b ();
  psum_window_acc_if #(.LANES(1), .DATA_W(8), .ACC_W(8)) if_c ();
  logic       en_bc, clr_bc, mode_bc;
  logic [1:0] fill_b, fill_c;
  logic [0:0] ovf_b, ovf_c;
  psum_window_acc #(.DATA_W(8), .ACC_W(8), .WIN(3), .LANES(1), .SAT(1'b1)) u_b (
    .clk(clk), .rst(rst), .en(en_bc), .clr(clr_bc), .mode(mode_bc),
    .bus(if_b.slave), .fill(fill_b), .ovf(ovf_b));
  psum_window_acc #(.DATA_W(8), .ACC_W(8), .WIN(3), .LANES(1), .SAT(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(en_bc), .clr(clr_bc), .mode(mode_bc),
    .bus(if_c.slave), .fill(fill_c), .ovf(ovf_c));

  // DUT D: two lanes
  psum_window_acc_if #(.LANES(2), .DATA_W(8), .ACC_W(16)) if_d ();
  logic       en_d, clr_d, mode_d;
  logic [1:0] fill_d;
  logic [1:0] ovf_d;
  psum_window_acc #(.DATA_W(8), .ACC_W(16), .WIN(3), .LANES(2), .SAT(1'b1)) u_d (
    .clk(clk), .rst(rst), .en(en_d), .clr(clr_d), .mode(mode_d),
    .bus(if_d.slave), .fill(fill_d), .ovf(ovf_d));

  task automatic push_a(input int x);
    if_a.in_data  = 8'(x);
    if_a.in_valid = 1'b1;
    #1;
    check("a_in_ready", int'(if_a.in_ready), 1);
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
  endtask

  task automatic push_bc(input int x);
    if_b.in_data  = 8'(x);
    if_c.in_data  = 8'(x);
    if_b.in_valid = 1'b1;
    if_c.in_valid = 1'b1;
    @(posedge clk); #1;
    if_b.in_valid = 1'b0;
    if_c.in_valid = 1'b0;
  endtask

  task automatic push_d(input int x0, input int x1);
    if_d.in_data  = {8'(x1), 8'(x0)};
    if_d.in_valid = 1'b1;
    @(posedge clk); #1;
    if_d.in_valid = 1'b0;
  endtask

  int sl_in  [5] = '{12, 5, 2, 7, -4};
  int sl_fil [5] = '{1, 2, 3, 3, 3};
  int sl_ov  [5] = '{0, 0, 1, 1, 1};
  int sl_out [5] = '{0, 0, 19, 14, 5};
  int tb_fil [6] = '{1, 2, 0, 1, 2, 0};
  int tb_ov  [6] = '{0, 0, 1, 0, 0, 1};
  int tb_out [6] = '{0, 0, 6, 0, 0, 15};
  int sc_in  [9] = '{10, 20, 30, 100, 100, 100, -128, -128, -128};
  int sc_b   [9] = '{0, 0, 60, 0, 0, 127, 0, 0, -128};
  int sc_c   [9] = '{0, 0, 60, 0, 0, 44, 0, 0, -128};
  int sc_ovf [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};

  initial begin
    rst = 1'b1;
    en_a = 1'b1;  clr_a = 1'b0;  mode_a = 1'b0;
    en_bc = 1'b1; clr_bc = 1'b0; mode_bc = 1'b1;
    en_d = 1'b1;  clr_d = 1'b0;  mode_d = 1'b0;
    if_a.in_data = '0; if_a.in_valid = 1'b0; if_a.out_ready = 1'b1;
    if_b.in_data = '0; if_b.in_valid = 1'b0; if_b.out_ready = 1'b1;
    if_c.in_data = '0; if_c.in_valid = 1'b0; if_c.out_ready = 1'b1;
    if_d.in_data = '0; if_d.in_valid = 1'b0; if_d.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_in_ready", int'(if_a.in_ready), 0);
    check("rst_out_valid", int'(if_a.out_valid), 0);
    check("rst_out_data", int'(if_a.out_data), 0);
    check("rst_fill", int'(fill_a), 0);
    check("rst_ovf", int'(ovf_a), 0);
    rst = 1'b0;

    // Sliding window, back-to-back
    for (int i = 0; i < 5; i++) begin
      push_a(sl_in[i]);
      check($sformatf("slide%0d_fill", i), int'(fill_a), sl_fil[i]);
      check($sformatf("slide%0d_valid", i), int'(if_a.out_valid), sl_ov[i]);
      if (sl_ov[i] != 0)
        check($sformatf("slide%0d_data", i), int'($signed(if_a.out_data)), sl_out[i]);
    end
    @(posedge clk); #1;
    check("slide_idle_valid", int'(if_a.out_valid), 0);

    // clr together with in_valid: sample dropped, window empty
    clr_a = 1'b1; @(posedge clk); #1; clr_a = 1'b0;
    check("clr_fill", int'(fill_a), 0);
    push_a(12);
    check("pre_clr_fill", int'(fill_a), 1);
    clr_a = 1'b1; if_a.in_data = 8'd5; if_a.in_valid = 1'b1;
    #1;
    check("clr_in_ready", int'(if_a.in_ready), 0);
    @(posedge clk); #1;
    clr_a = 1'b0; if_a.in_valid = 1'b0;
    check("clr_valid_fill", int'(fill_a), 0);

    // Backpressure then en freeze
    push_a(12); push_a(5); push_a(2);
    check("bp_first_out", int'($signed(if_a.out_data)), 19);
    if_a.out_ready = 1'b0;
    if_a.in_data = 8'd7; if_a.in_valid = 1'b1;
    #1;
    check("bp_in_ready", int'(if_a.in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_valid", int'(if_a.out_valid), 1);
    check("bp_hold_data", int'($signed(if_a.out_data)), 19);
    check("bp_hold_fill", int'(fill_a), 3);
    if_a.out_ready = 1'b1;
    #1;
    check("bp_release_ready", int'(if_a.in_ready), 1);
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
    check("bp_resume_data", int'($signed(if_a.out_data)), 14);
    en_a = 1'b0;
    if_a.in_data = 8'(-4); if_a.in_valid = 1'b1;
    #1;
    check("en0_in_ready", int'(if_a.in_ready), 0);
    repeat (5) @(posedge clk);
    #1;
    check("en0_valid", int'(if_a.out_valid), 1);
    check("en0_data", int'($signed(if_a.out_data)), 14);
    check("en0_fill", int'(fill_a), 3);
    en_a = 1'b1;
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
    check("en1_data", int'($signed(if_a.out_data)), 5);

    // Tumbling blocks of 3
    clr_a = 1'b1; @(posedge clk); #1; clr_a = 1'b0;
    mode_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_a(i + 1);
      check($sformatf("tumble%0d_fill", i), int'(fill_a), tb_fil[i]);
      check($sformatf("tumble%0d_valid", i), int'(if_a.out_valid), tb_ov[i]);
      if (tb_ov[i] != 0)
        check($sformatf("tumble%0d_data", i), int'($signed(if_a.out_data)), tb_out[i]);
    end
    check("tumble_ovf", int'(ovf_a), 0);

    // Saturate (B) vs wrap (C) on 8-bit outputs, tumbling
    for (int i = 0; i < 9; i++) begin
      push_bc(sc_in[i]);
      if ((i % 3) == 2) begin
        check($sformatf("sat%0d_data", i), int'($signed(if_b.out_data)), sc_b[i]);
        check($sformatf("wrap%0d_data", i), int'($signed(if_c.out_data)), sc_c[i]);
        check($sformatf("sat%0d_ovf", i), int'(ovf_b), sc_ovf[i]);
        check($sformatf("wrap%0d_ovf", i), int'(ovf_c), sc_ovf[i]);
      end
    end
    check("sat_fill", int'(fill_b), 0);

    // Two lanes, clr mid-window
    push_d(3, -1);
    push_d(4, -2);
    check("d_pre_fill", int'(fill_d), 2);
    check("d_pre_valid", int'(if_d.out_valid), 0);
    clr_d = 1'b1; @(posedge clk); #1; clr_d = 1'b0;
    check("d_clr_fill", int'(fill_d), 0);
    check("d_clr_valid", int'(if_d.out_valid), 0);
    push_d(1, 1); push_d(1, 1);
    check("d_mid_valid", int'(if_d.out_valid), 0);
    push_d(1, 1);
    check("d_out_valid", int'(if_d.out_valid), 1);
    check("d_lane0", int'($signed(if_d.out_data[15:0])), 3);
    check("d_lane1", int'($signed(if_d.out_data[31:16])), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
